// File: rtl/no_lut_node.sv
// Boolean-network node with a runtime-loadable truth table.
// Two copies of the node state are kept: s0 advances on every SLOW_DIV-th
// start_s0 strobe, s1 on every start_s1 strobe, so a cycle detector can compare
// them (tortoise/hare). s1 value changes are counted with a saturating counter.
module no_lut_node #(
    parameter int NUM_INPUTS = 3,
    parameter logic [(1 << NUM_INPUTS)-1:0] LUT_INIT = 8'hEA,
    parameter int SLOW_DIV = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reset_nos,
    input  logic                  init_state,
    input  logic                  start_s0,
    input  logic                  start_s1,
    input  logic [NUM_INPUTS-1:0] in_s0,
    input  logic [NUM_INPUTS-1:0] in_s1,
    input  logic                  cfg_we,
    input  logic [NUM_INPUTS-1:0] cfg_addr,
    input  logic                  cfg_data,
    output logic                  s0,
    output logic                  s1,
    output logic                  chg_s0,
    output logic                  chg_s1,
    output logic [CNT_W-1:0]      flips_s1,
    output logic                  eq
);

    localparam int LUT_N = 1 << NUM_INPUTS;
    localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SLOW_DIV - 1);

    logic [LUT_N-1:0] lut_q, lut_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             chg0_q, chg0_d;
    logic             chg1_q, chg1_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] flips_q, flips_d;
    logic             next0, next1;

    // Both copies look up the table as it stood before this edge.
    always_comb begin
        next0 = lut_q[in_s0];
        next1 = lut_q[in_s1];
    end

    // Next-state: table writes, per-run reinit, slow divider and fast update.
    always_comb begin
        lut_d   = lut_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        chg0_d  = 1'b0;
        chg1_d  = 1'b0;
        div_d   = div_q;
        flips_d = flips_q;

        if (cfg_we) begin
            lut_d[cfg_addr] = cfg_data;
        end

        if (reset_nos) begin
            s0_d    = init_state;
            s1_d    = init_state;
            div_d   = DIV_MAX;
            flips_d = '0;
        end else begin
            if (start_s0) begin
                if (div_q == DIV_MAX) begin
                    s0_d   = next0;
                    chg0_d = (next0 != s0_q);
                    div_d  = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            if (start_s1) begin
                s1_d   = next1;
                chg1_d = (next1 != s1_q);
                if ((next1 != s1_q) && (flips_q != {CNT_W{1'b1}})) begin
                    flips_d = flips_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers; rst restores the power-up table and clears the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q   <= LUT_INIT;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            chg0_q  <= 1'b0;
            chg1_q  <= 1'b0;
            div_q   <= DIV_MAX;
            flips_q <= '0;
        end else begin
            lut_q   <= lut_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            chg0_q  <= chg0_d;
            chg1_q  <= chg1_d;
            div_q   <= div_d;
            flips_q <= flips_d;
        end
    end

    // Output mapping; eq is deliberately combinational on the registered copies.
    always_comb begin
        s0       = s0_q;
        s1       = s1_q;
        chg_s0   = chg0_q;
        chg_s1   = chg1_q;
        flips_s1 = flips_q;
        eq       = (s0_q == s1_q);
    end

endmodule
